// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one requester per two-cycle IDLE/ACCESS
// window, aligns write lanes and byte enables, and returns the raw read word.
module dmem_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic        we_0,
    input  logic [31:0] addr_0,
    input  logic [1:0]  size_0,
    input  logic [31:0] wdata_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic [31:0] addr_1,
    input  logic [1:0]  size_1,
    input  logic [31:0] wdata_1,
    output logic        gnt_0,
    output logic        done_0,
    output logic        err_0,
    output logic [31:0] rdata_0,
    output logic        gnt_1,
    output logic        done_1,
    output logic        err_1,
    output logic [31:0] rdata_1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic        last_r, we_r, port_r, mis_r;
    logic        any_req_s, win_s, sel_we_s, mis_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [1:0]  sel_size_s;

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   misaligned_f = 1'b0;
            2'b01:   misaligned_f = a[0];
            2'b10:   misaligned_f = (a != 2'b00);
            default: misaligned_f = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   be_f = 4'b0001 << a;
            2'b01:   be_f = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   be_f = 4'b1111;
            default: be_f = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_f(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_f = {4{wd[7:0]}};
            2'b01:   lane_f = {2{wd[15:0]}};
            default: lane_f = wd;
        endcase
    endfunction

    // Winner selection: on a tie, round-robin favours the port not served last
    always_comb begin
        any_req_s = req_0 | req_1;
        win_s     = 1'b0;
        if (req_0 && req_1) begin
            if (RR_EN != 0) begin
                win_s = ~last_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (req_1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    assign sel_we_s    = win_s ? we_1    : we_0;
    assign sel_addr_s  = win_s ? addr_1  : addr_0;
    assign sel_size_s  = win_s ? size_1  : size_0;
    assign sel_wdata_s = win_s ? wdata_1 : wdata_0;
    assign mis_s       = misaligned_f(sel_size_s, sel_addr_s[1:0]);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered grant, strobe, completion and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            we_r      <= 1'b0;
            port_r    <= 1'b0;
            mis_r     <= 1'b0;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            err_0     <= 1'b0;
            err_1     <= 1'b0;
            rdata_0   <= 32'd0;
            rdata_1   <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    done_0    <= 1'b0;
                    done_1    <= 1'b0;
                    err_0     <= 1'b0;
                    err_1     <= 1'b0;
                    gnt_0     <= any_req_s & ~win_s;
                    gnt_1     <= any_req_s & win_s;
                    // misaligned accesses are granted but never touch memory
                    mem_read  <= any_req_s & ~sel_we_s & ~mis_s;
                    mem_write <= any_req_s & sel_we_s & ~mis_s;
                    mem_be    <= (any_req_s && !mis_s) ? be_f(sel_size_s, sel_addr_s[1:0]) : 4'b0000;
                    if (any_req_s) begin
                        we_r      <= sel_we_s;
                        port_r    <= win_s;
                        mis_r     <= mis_s;
                        last_r    <= win_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= lane_f(sel_size_s, sel_wdata_s);
                    end
                end
                ACCESS: begin
                    gnt_0     <= 1'b0;
                    gnt_1     <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_be    <= 4'b0000;
                    done_0    <= ~port_r;
                    done_1    <= port_r;
                    err_0     <= ~port_r & mis_r;
                    err_1     <= port_r & mis_r;
                    if (!we_r && !mis_r) begin
                        if (port_r) begin
                            rdata_1 <= mem_rdata;
                        end else begin
                            rdata_0 <= mem_rdata;
                        end
                    end
                end
                default: begin
                    gnt_0     <= 1'b0;
                    gnt_1     <= 1'b0;
                    done_0    <= 1'b0;
                    done_1    <= 1'b0;
                    err_0     <= 1'b0;
                    err_1     <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_be    <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin and fixed-priority instances share
// stimulus; per-instance queues hold expected grants and completions.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_0, we_0, req_1, we_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1, mem_rdata;
    logic [1:0]  size_0, size_1;

    logic        rr_gnt_0, rr_done_0, rr_err_0, rr_gnt_1, rr_done_1, rr_err_1;
    logic        rr_mem_read, rr_mem_write;
    logic [3:0]  rr_mem_be;
    logic [31:0] rr_rdata_0, rr_rdata_1, rr_mem_addr, rr_mem_wdata;
    logic        fp_gnt_0, fp_done_0, fp_err_0, fp_gnt_1, fp_done_1, fp_err_1;
    logic        fp_mem_read, fp_mem_write;
    logic [3:0]  fp_mem_be;
    logic [31:0] fp_rdata_0, fp_rdata_1, fp_mem_addr, fp_mem_wdata;

    dmem_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .size_0(size_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .size_1(size_1), .wdata_1(wdata_1),
        .gnt_0(rr_gnt_0), .done_0(rr_done_0), .err_0(rr_err_0), .rdata_0(rr_rdata_0),
        .gnt_1(rr_gnt_1), .done_1(rr_done_1), .err_1(rr_err_1), .rdata_1(rr_rdata_1),
        .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_be(rr_mem_be),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .size_0(size_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .size_1(size_1), .wdata_1(wdata_1),
        .gnt_0(fp_gnt_0), .done_0(fp_done_0), .err_0(fp_err_0), .rdata_0(fp_rdata_0),
        .gnt_1(fp_gnt_1), .done_1(fp_done_1), .err_1(fp_err_1), .rdata_1(fp_rdata_1),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_be(fp_mem_be),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        port;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        want_done;
    } exp_t;

    exp_t gq0[$], gq1[$], dq0[$], dq1[$];

    function automatic logic [31:0] pat(input int c);
        logic [31:0] cv;
        cv = c;
        return {16'hC0DE, cv[15:0]};
    endfunction

    function automatic exp_t mk(input int cy, input logic p, rd, wr, input logic [3:0] be,
                                input logic [31:0] ad, wd, input logic er, chkr,
                                input logic [31:0] rdt, input logic wdone);
        exp_t e;
        e.cyc = cy; e.port = p; e.rd = rd; e.wr = wr; e.be = be; e.addr = ad; e.wd = wd;
        e.err = er; e.chk_rd = chkr; e.rdata = rdt; e.want_done = wdone;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input string tag, input logic g0, g1, dn0, dn1, e0, e1, mr, mw,
                       input logic [3:0] be, input logic [31:0] ad, wd, r0, r1);
        exp_t e;
        int   n;
        if (g0 | g1) begin
            n = (d == 0) ? gq0.size() : gq1.size();
            if (n == 0) begin
                chk({tag, "_gnt_unexpected"}, {30'd0, g1, g0}, 32'd0);
            end else begin
                if (d == 0) e = gq0.pop_front(); else e = gq1.pop_front();
                chk({tag, "_gnt_cycle"}, cyc, e.cyc);
                chk({tag, "_gnt_port"}, {30'd0, g1, g0}, e.port ? 32'd2 : 32'd1);
                chk({tag, "_mem_strobe"}, {30'd0, mr, mw}, {30'd0, e.rd, e.wr});
                chk({tag, "_mem_be"}, {28'd0, be}, {28'd0, e.be});
                chk({tag, "_mem_addr"}, ad, e.addr);
                if (e.wr) chk({tag, "_mem_wdata"}, wd, e.wd);
                if (e.want_done) begin
                    if (d == 0) dq0.push_back(e); else dq1.push_back(e);
                end
            end
        end else begin
            chk({tag, "_idle_strobe"}, {26'd0, mr, mw, be}, 32'd0);
        end
        if (dn0 | dn1) begin
            n = (d == 0) ? dq0.size() : dq1.size();
            if (n == 0) begin
                chk({tag, "_done_unexpected"}, {30'd0, dn1, dn0}, 32'd0);
            end else begin
                if (d == 0) e = dq0.pop_front(); else e = dq1.pop_front();
                chk({tag, "_done_cycle"}, cyc, e.cyc + 1);
                chk({tag, "_done_port"}, {30'd0, dn1, dn0}, e.port ? 32'd2 : 32'd1);
                chk({tag, "_err"}, {30'd0, e1, e0}, e.err ? (e.port ? 32'd2 : 32'd1) : 32'd0);
                if (e.chk_rd) chk({tag, "_rdata"}, e.port ? r1 : r0, e.rdata);
            end
        end else begin
            chk({tag, "_idle_err"}, {30'd0, e1, e0}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1)
            mon(0, "rr", rr_gnt_0, rr_gnt_1, rr_done_0, rr_done_1, rr_err_0, rr_err_1,
                rr_mem_read, rr_mem_write, rr_mem_be, rr_mem_addr, rr_mem_wdata, rr_rdata_0, rr_rdata_1);
    end

    always @(negedge clk) begin
        if (cyc >= 1)
            mon(1, "fp", fp_gnt_0, fp_gnt_1, fp_done_0, fp_done_1, fp_err_0, fp_err_1,
                fp_mem_read, fp_mem_write, fp_mem_be, fp_mem_addr, fp_mem_wdata, fp_rdata_0, fp_rdata_1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = pat(cyc);
    endtask

    // One isolated request: issued now, granted next cycle, completed the cycle after
    task automatic single(input logic p, we, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input logic erd, ewr, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic eerr, echk, input logic [31:0] rdv);
        exp_t e;
        int   c;
        c = cyc;
        e = mk(c + 1, p, erd, ewr, ebe, a, ewd, eerr, echk, (rdv != 32'd0) ? rdv : pat(c + 1), 1'b1);
        gq0.push_back(e);
        gq1.push_back(e);
        if (p) begin
            req_1 = 1'b1; we_1 = we; addr_1 = a; size_1 = sz; wdata_1 = wd;
        end else begin
            req_0 = 1'b1; we_0 = we; addr_0 = a; size_0 = sz; wdata_0 = wd;
        end
        tick();
        req_0 = 1'b0;
        req_1 = 1'b0;
        if (rdv != 32'd0) mem_rdata = rdv;
        tick();
    endtask

    initial begin
        int c;
        rst = 1'b1;
        req_0 = 1'b0; we_0 = 1'b0; addr_0 = 32'd0; size_0 = 2'b00; wdata_0 = 32'd0;
        req_1 = 1'b0; we_1 = 1'b0; addr_1 = 32'd0; size_1 = 2'b00; wdata_1 = 32'd0;
        mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_rr_ctl", {23'd0, rr_gnt_1, rr_gnt_0, rr_done_1, rr_done_0, rr_err_1, rr_err_0,
                           rr_mem_read, rr_mem_write, rr_mem_be}, 32'd0);
        chk("rst_fp_ctl", {23'd0, fp_gnt_1, fp_gnt_0, fp_done_1, fp_done_0, fp_err_1, fp_err_0,
                           fp_mem_read, fp_mem_write, fp_mem_be}, 32'd0);
        chk("rst_rr_rdata0", rr_rdata_0, 32'd0);
        chk("rst_rr_rdata1", rr_rdata_1, 32'd0);
        rst = 1'b0;

        single(1'b0, 1'b1, 32'h2000_0008, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        single(1'b1, 1'b1, 32'h2000_0003, 2'b00, 32'h0000_00A5, 1'b0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'd0);
        single(1'b0, 1'b1, 32'h2000_0006, 2'b01, 32'h1234_ABCD, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'd0);
        single(1'b1, 1'b0, 32'h0000_0101, 2'b00, 32'd0,         1'b1, 1'b0, 4'b0010, 32'd0,         1'b0, 1'b1, 32'd0);
        single(1'b0, 1'b0, 32'h0000_0000, 2'b11, 32'd0,         1'b0, 1'b0, 4'b0000, 32'd0,         1'b1, 1'b0, 32'd0);
        single(1'b0, 1'b0, 32'h0000_0002, 2'b10, 32'd0,         1'b0, 1'b0, 4'b0000, 32'd0,         1'b1, 1'b0, 32'd0);
        single(1'b0, 1'b0, 32'h0010_0000, 2'b10, 32'd0,         1'b1, 1'b0, 4'b1111, 32'd0,         1'b0, 1'b1, 32'h1719_2051);
        single(1'b1, 1'b1, 32'h2000_0001, 2'b01, 32'h0000_5A5A, 1'b0, 1'b0, 4'b0000, 32'd0,         1'b1, 1'b0, 32'd0);

        // Continuous tie after a port-1 access: RR alternates from port 0, fixed priority keeps port 0
        c = cyc;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h0000_0040; size_0 = 2'b10;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h0000_0080; size_1 = 2'b10;
        for (int k = 0; k < 4; k++) begin
            gq0.push_back(mk(c + 1 + 2 * k, k[0], 1'b1, 1'b0, 4'b1111,
                             k[0] ? 32'h0000_0080 : 32'h0000_0040, 32'd0, 1'b0, 1'b1, pat(c + 1 + 2 * k), 1'b1));
            gq1.push_back(mk(c + 1 + 2 * k, 1'b0, 1'b1, 1'b0, 4'b1111,
                             32'h0000_0040, 32'd0, 1'b0, 1'b1, pat(c + 1 + 2 * k), 1'b1));
        end
        for (int k = 0; k < 7; k++) tick();
        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();

        // Tie granted to port 0, then reset mid-access: no completion may follow
        c = cyc;
        req_0 = 1'b1;
        req_1 = 1'b1;
        gq0.push_back(mk(c + 1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
        gq1.push_back(mk(c + 1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
        tick();
        rst = 1'b1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_rr_ctl", {23'd0, rr_gnt_1, rr_gnt_0, rr_done_1, rr_done_0, rr_err_1, rr_err_0,
                             rr_mem_read, rr_mem_write, rr_mem_be}, 32'd0);
        chk("abort_rr_rdata0", rr_rdata_0, 32'd0);
        chk("abort_rr_rdata1", rr_rdata_1, 32'd0);
        chk("abort_fp_rdata0", fp_rdata_0, 32'd0);

        c = cyc;
        req_0 = 1'b1;
        req_1 = 1'b1;
        gq0.push_back(mk(c + 1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'd0, 1'b0, 1'b1, pat(c + 1), 1'b1));
        gq1.push_back(mk(c + 1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'd0, 1'b0, 1'b1, pat(c + 1), 1'b1));
        tick();
        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        chk("rr_pending", gq0.size() + dq0.size(), 32'd0);
        chk("fp_pending", gq1.size() + dq1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
